serv_lsu_buf: RTL
=================

SERV_LSU_BUF -- requirements
Module: serv_lsu_buf

Interface
REQ-001 SHALL have parameter WITH_MISALIGN, default 1, meaning misaligned-access detection is enabled (0: low address bits ignored, lanes forced aligned).
REQ-002 SHALL have port i_clk  in  1  the single clock; all state changes on the rising edge.
REQ-003 SHALL have port i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports i_mem_op in 1 (start pulse, address valid) and i_we in 1 (1 = store).
REQ-005 SHALL have ports i_size in 2 (00 byte, 01 half, 10 word; 11 treated as word) and i_signed in 1 (load sign-extend).
REQ-006 SHALL have ports i_adr in 32 (word address, bits[1:0] = 0) and i_lsb in 2 (byte offset), both sampled at i_mem_op.
REQ-007 SHALL have ports i_en in 1 (serial bit strobe) and i_rs2 in 1 (serial store data, LSB first).
REQ-008 SHALL have port o_rd out 1: serial load data, LSB first, forced 0 when i_en = 0.
REQ-009 SHALL have bus ports o_dbus_adr out 32, o_dbus_dat out 32, o_dbus_sel out 4, o_dbus_we out 1, o_dbus_cyc out 1, i_dbus_ack in 1, i_dbus_rdt in 32.
REQ-010 SHALL have status ports o_busy out 1, o_done out 1 (one-cycle pulse), o_misalign out 1 (one-cycle pulse).

Function
REQ-011 SHALL implement states IDLE, FILL, REQ, DRAIN with a 5-bit bit counter and a 32-bit data register.
REQ-012 IDLE + i_mem_op: latch adr/lsb/size/signed/we; misaligned (half with lsb[0]=1, word with lsb != 0, WITH_MISALIGN=1) -> pulse o_misalign next cycle, stay IDLE, no bus cycle.
REQ-013 IDLE + aligned store -> FILL; aligned load -> REQ with o_dbus_cyc = 1 from the next cycle.
REQ-014 FILL: each i_en cycle shifts i_rs2 into data[31] (right shift) and increments counter; 32nd i_en (counter = 31) -> REQ.
REQ-015 REQ: o_dbus_cyc, o_dbus_adr, o_dbus_sel, o_dbus_we, o_dbus_dat held stable until cycle where i_dbus_ack = 1; cyc deasserts the following cycle.
REQ-016 Store in REQ: o_dbus_dat = byte replicated x4 / half replicated x2 / word as-is; o_dbus_sel = 0001<<lsb (byte), 0011<<(2*lsb[1]) (half), 1111 (word).
REQ-017 Store ack -> IDLE, o_done pulses in the cycle after ack.
REQ-018 Load ack: capture i_dbus_rdt >> (8*lsb) into data register, clear counter -> DRAIN; o_dbus_sel per REQ-016, o_dbus_we = 0.
REQ-019 DRAIN: each i_en cycle emits one bit: bit index < width (8/16/32) emits data bit; else emits sign bit (bit 7/15) if i_signed, else 0.
REQ-020 DRAIN 32nd i_en -> IDLE, o_done pulses next cycle.
REQ-021 o_busy = 1 in every state except IDLE.
REQ-022 i_mem_op while not IDLE SHALL be ignored; i_dbus_ack while o_dbus_cyc = 0 SHALL be ignored.
REQ-023 i_en = 0 SHALL freeze counter and data in FILL/DRAIN (stall-tolerant); counter wraps 31 -> 0 only on state exit.
REQ-024 Ack in same cycle cyc first asserts is not possible (cyc registered); ack in first cyc cycle SHALL complete normally.

Reset
REQ-025 i_rst_n = 0 SHALL immediately force state IDLE, counter 0, o_dbus_cyc 0, o_done 0, o_misalign 0, o_busy 0, o_rd 0, data register 0, latched address 0.
REQ-026 Reset mid-REQ SHALL drop o_dbus_cyc asynchronously; no o_done is produced for the aborted access.

Structure
REQ-027 Shared package serv_lsu_pkg SHALL hold the state enum and size-code constants (SIZE_B, SIZE_H, SIZE_W).
REQ-028 One combinational sub-module serv_lsu_align SHALL produce o_dbus_sel, replicated store data and the right-shifted load word from size and lsb.

Verification
REQ-029 Store word: i_adr=0x100, lsb=0, rs2 stream 0xDEADBEEF over 32 i_en, ack after 3 cycles -> dat=0xDEADBEEF, sel=1111, we=1, one o_done.
REQ-030 Signed byte load: adr=0x200, lsb=3, rdt=0x80123456, ack at once -> 32 serial bits = 0xFFFFFF80.
REQ-031 Unsigned half load: lsb=2, rdt=0xBEEF0000 -> serial 0x0000BEEF, sel=1100.
REQ-032 Misaligned word store lsb=1 -> o_misalign one cycle, o_dbus_cyc never 1, o_busy 0.
REQ-033 Reset low for 1 cycle mid-REQ with cyc=1 -> cyc 0 immediately, state IDLE, no o_done; later store completes normally.
REQ-034 DRAIN with i_en toggling 1/0 -> same 32 bits as continuous i_en, o_done after exactly 32 strobes.

Source files
------------

// File: rtl/serv_lsu_pkg.sv
// Shared types and size codes for the serial load/store buffer.
package serv_lsu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      REQ   = 2'd2,
      DRAIN = 2'd3
   } lsu_state_e;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   // Number of meaningful data bits for an access size; 11 behaves as a word.
   function automatic logic [5:0] size_bits(input logic [1:0] size);
      case (size)
         SIZE_B:  size_bits = 6'd8;
         SIZE_H:  size_bits = 6'd16;
         default: size_bits = 6'd32;
      endcase
   endfunction

endpackage

// File: rtl/serv_lsu_align.sv
// Byte-lane steering: bus select, replicated store data and right-aligned load word.
module serv_lsu_align
   import serv_lsu_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_lsb,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdt,
   output logic [3:0]  o_sel,
   output logic [31:0] o_wdat,
   output logic [31:0] o_rdata
);

   // Narrow stores are replicated across the word so any selected lane carries the data.
   always_comb begin
      o_sel  = 4'b1111;
      o_wdat = i_wdata;
      case (i_size)
         SIZE_B: begin
            o_sel  = 4'b0001 << i_lsb;
            o_wdat = {4{i_wdata[7:0]}};
         end
         SIZE_H: begin
            o_sel  = 4'b0011 << {i_lsb[1], 1'b0};
            o_wdat = {2{i_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign o_rdata = i_rdt >> {i_lsb, 3'b000};

endmodule

// File: rtl/serv_lsu_buf.sv
// Bit-serial load/store buffer bridging a serial datapath to a 32-bit Wishbone-like bus.
module serv_lsu_buf
   import serv_lsu_pkg::*;
#(
   parameter bit WITH_MISALIGN = 1'b1
)
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_mem_op,
   input  logic        i_we,
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   input  logic [31:0] i_adr,
   input  logic [1:0]  i_lsb,
   input  logic        i_en,
   input  logic        i_rs2,
   output logic        o_rd,
   output logic [31:0] o_dbus_adr,
   output logic [31:0] o_dbus_dat,
   output logic [3:0]  o_dbus_sel,
   output logic        o_dbus_we,
   output logic        o_dbus_cyc,
   input  logic        i_dbus_ack,
   input  logic [31:0] i_dbus_rdt,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_misalign
);

   lsu_state_e  state, state_n;
   logic [4:0]  cnt, cnt_n;
   logic [31:0] data, data_n;
   logic [31:0] adr, adr_n;
   logic [1:0]  lsb, lsb_n;
   logic [1:0]  size, size_n;
   logic        sext, sext_n;
   logic        we, we_n;
   logic        done_n, misalign_n;

   logic [1:0]  req_size, req_lsb;
   logic        req_misalign;
   logic [31:0] rdata_aligned;
   logic [5:0]  width;
   logic        sign_bit;

   serv_lsu_align u_align (
      .i_size  (size),
      .i_lsb   (lsb),
      .i_wdata (data),
      .i_rdt   (i_dbus_rdt),
      .o_sel   (o_dbus_sel),
      .o_wdat  (o_dbus_dat),
      .o_rdata (rdata_aligned)
   );

   // With misalign detection off, the offset is rounded down to the access size.
   always_comb begin
      req_size     = (i_size == 2'b11) ? SIZE_W : i_size;
      req_misalign = WITH_MISALIGN &&
                     (((req_size == SIZE_H) && i_lsb[0]) ||
                      ((req_size == SIZE_W) && (i_lsb != 2'b00)));
      req_lsb      = i_lsb;
      if (!WITH_MISALIGN) begin
         case (req_size)
            SIZE_H:  req_lsb = {i_lsb[1], 1'b0};
            SIZE_W:  req_lsb = 2'b00;
            default: req_lsb = i_lsb;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         data       <= '0;
         adr        <= '0;
         lsb        <= '0;
         size       <= SIZE_B;
         sext       <= 1'b0;
         we         <= 1'b0;
         o_done     <= 1'b0;
         o_misalign <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         data       <= data_n;
         adr        <= adr_n;
         lsb        <= lsb_n;
         size       <= size_n;
         sext       <= sext_n;
         we         <= we_n;
         o_done     <= done_n;
         o_misalign <= misalign_n;
      end
   end

   // Counter and data only move on i_en so the serial side may stall freely.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      data_n     = data;
      adr_n      = adr;
      lsb_n      = lsb;
      size_n     = size;
      sext_n     = sext;
      we_n       = we;
      done_n     = 1'b0;
      misalign_n = 1'b0;
      case (state)
         IDLE: begin
            if (i_mem_op) begin
               adr_n  = i_adr;
               lsb_n  = req_lsb;
               size_n = req_size;
               sext_n = i_signed;
               we_n   = i_we;
               if (req_misalign) begin
                  misalign_n = 1'b1;
               end else begin
                  state_n = i_we ? FILL : REQ;
               end
            end
         end
         FILL: begin
            if (i_en) begin
               data_n = {i_rs2, data[31:1]};
               cnt_n  = cnt + 5'd1;
               if (cnt == 5'd31) state_n = REQ;
            end
         end
         REQ: begin
            if (i_dbus_ack) begin
               if (we) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else begin
                  data_n  = rdata_aligned;
                  cnt_n   = '0;
                  state_n = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (i_en) begin
               cnt_n = cnt + 5'd1;
               if (cnt == 5'd31) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Bits past the access width carry the sign (signed loads) or zero.
   always_comb begin
      width    = size_bits(size);
      sign_bit = (size == SIZE_B) ? data[7] : data[15];
      o_rd     = 1'b0;
      if ((state == DRAIN) && i_en) begin
         o_rd = ({1'b0, cnt} < width) ? data[cnt] : (sext & sign_bit);
      end
   end

   assign o_dbus_cyc = (state == REQ);
   assign o_dbus_adr = adr;
   assign o_dbus_we  = we;
   assign o_busy     = (state != IDLE);

endmodule
